lcd_read_scheduler: RTL and testbench



---
 rtl/lcd_read_scheduler_if.sv | 10 +
 rtl/lcd_read_scheduler.sv | 98 +++++++++
 tb/tb_lcd_read_scheduler.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_read_scheduler_if.sv
// lcd_read_scheduler_if: SDRAM controller read-port handshake (burst request/ack/done).
interface lcd_read_scheduler_if #(parameter int ADDR_W = 24);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [8:0]        rd_len;
    logic              rd_ack;
    logic              rd_done;
    modport master(output rd_req, rd_addr, rd_len, input rd_ack, rd_done);
    modport slave(input rd_req, rd_addr, rd_len, output rd_ack, rd_done);
endinterface

// File: rtl/lcd_read_scheduler.sv
// lcd_read_scheduler: schedules SDRAM read bursts into the LCD line FIFO, restarting on vsync fall.
// Optional LCD_SCHED_DOUBLE_BUF_EN selects the frame bank (wr_bank/rd_bank, BANK_OFFSET).
module lcd_read_scheduler #(
    parameter int                ADDR_W      = 24,
    parameter logic [ADDR_W-1:0] FRAME_BASE  = '0,
    parameter int                FRAME_WORDS = 345600,
    parameter int                BURST_LEN   = 256,
    parameter int                FIFO_DEPTH  = 1024,
    parameter int                FIFO_AW     = 10
`ifdef LCD_SCHED_DOUBLE_BUF_EN
    , parameter logic [ADDR_W-1:0] BANK_OFFSET = ADDR_W'(24'h080000)
`endif
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_sync,
    input  logic [FIFO_AW:0]    fifo_level,
    output logic                fifo_clr,
    output logic                frame_active,
    output logic                frame_late,
`ifdef LCD_SCHED_DOUBLE_BUF_EN
    input  logic                wr_bank,
    output logic                rd_bank,
`endif
    lcd_read_scheduler_if.master rd
);
    typedef enum logic [2:0] {IDLE, FLUSH, CHECK, REQ, WAIT, DONE} state_t;
    state_t            state, state_n;
    logic              fs_d, start, pend, fits;
    logic [19:0]       remaining;
    logic [ADDR_W-1:0] addr, base, rd_addr_q;
    logic [8:0]        len, rd_len_q;
`ifdef LCD_SCHED_DOUBLE_BUF_EN
    assign base = FRAME_BASE + (wr_bank ? BANK_OFFSET : '0);
`else
    assign base = FRAME_BASE;
`endif
    assign start      = fs_d & ~frame_sync;
    assign len        = (remaining >= 20'(BURST_LEN)) ? 9'(BURST_LEN) : remaining[8:0];
    assign fits       = 32'(fifo_level) + 32'(len) <= 32'(FIFO_DEPTH);
    assign fifo_clr   = state == FLUSH;
    assign rd.rd_req  = state == REQ;
    assign rd.rd_addr = rd_addr_q;
    assign rd.rd_len  = rd_len_q;
    // an ack in the same cycle as start still commits the burst
    always_comb begin
        state_n = state;
        case (state)
            IDLE, DONE: state_n = start ? FLUSH : state;
            FLUSH:      state_n = CHECK;
            CHECK:      state_n = start ? FLUSH : (remaining == '0) ? DONE : fits ? REQ : CHECK;
            REQ:        state_n = rd.rd_ack ? WAIT : start ? FLUSH : REQ;
            WAIT:       state_n = !rd.rd_done ? WAIT : (pend || start) ? FLUSH : CHECK;
            default:    state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            fs_d         <= 1'b1;
            pend         <= 1'b0;
            remaining    <= '0;
            addr         <= '0;
            rd_addr_q    <= '0;
            rd_len_q     <= '0;
            frame_active <= 1'b0;
            frame_late   <= 1'b0;
`ifdef LCD_SCHED_DOUBLE_BUF_EN
            rd_bank      <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            fs_d       <= frame_sync;
            frame_late <= start && (state == CHECK || state == REQ || state == WAIT);
            if (state == FLUSH) begin
                frame_active <= 1'b1;
                addr         <= base;
                remaining    <= 20'(FRAME_WORDS);
                pend         <= 1'b0;
`ifdef LCD_SCHED_DOUBLE_BUF_EN
                rd_bank      <= wr_bank;
`endif
            end
            if (state == CHECK && state_n == DONE)
                frame_active <= 1'b0;
            if (state == CHECK && state_n == REQ) begin
                rd_addr_q <= addr;
                rd_len_q  <= len;
            end
            if (start && (state == WAIT || (state == REQ && rd.rd_ack)))
                pend <= 1'b1;
            if (state == WAIT && rd.rd_done) begin
                addr      <= addr + ADDR_W'(rd_len_q);
                remaining <= remaining - 20'(rd_len_q);
            end
        end
    end
endmodule

// File: tb/tb_lcd_read_scheduler.sv
// tb_lcd_read_scheduler: directed bench with a burst scoreboard for lcd_read_scheduler (600-word frame).
module tb_lcd_read_scheduler;
    localparam int FW = 600;
    typedef struct packed {logic [23:0] addr; logic [8:0] len;} burst_t;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_sync = 1'b1;
    logic [10:0] fifo_level = '0;
    logic        fifo_clr, frame_active, frame_late;
`ifdef LCD_SCHED_DOUBLE_BUF_EN
    logic        wr_bank = 1'b0;
    logic        rd_bank;
`endif
    int          n_chk = 0;
    int          n_fail = 0;
    burst_t      exp_q[$];
    lcd_read_scheduler_if rd_if();
    lcd_read_scheduler #(.FRAME_WORDS(FW)) dut (
        .clk(clk), .rst(rst), .frame_sync(frame_sync), .fifo_level(fifo_level),
        .fifo_clr(fifo_clr), .frame_active(frame_active), .frame_late(frame_late),
`ifdef LCD_SCHED_DOUBLE_BUF_EN
        .wr_bank(wr_bank), .rd_bank(rd_bank),
`endif
        .rd(rd_if.master)
    );
    always #5 clk = ~clk;
    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic push_b(input logic [23:0] a, input logic [8:0] l);
        burst_t b;
        b.addr = a;
        b.len  = l;
        exp_q.push_back(b);
    endtask
    task automatic push_frame(input logic [23:0] base);
        for (int a = 0; a < FW; a += 256)
            push_b(base + 24'(a), (FW - a >= 256) ? 9'd256 : 9'(FW - a));
    endtask
    task automatic vsync_fall;
        frame_sync = 1'b0;
        tick();
        frame_sync = 1'b1;
    endtask
    task automatic expect_req(input int budget);
        burst_t b;
        int k = 0;
        while (rd_if.rd_req !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        chk("req_seen", 32'(rd_if.rd_req), 1);
        if (exp_q.size() == 0)
            chk("unexpected_req", 32'(exp_q.size()), 1);
        else begin
            b = exp_q.pop_front();
            chk("burst_addr", 32'(rd_if.rd_addr), 32'(b.addr));
            chk("burst_len", 32'(rd_if.rd_len), 32'(b.len));
        end
    endtask
    task automatic serve(input int budget);
        expect_req(budget);
        rd_if.rd_ack = 1'b1;
        tick();
        rd_if.rd_ack = 1'b0;
        chk("req_drop", 32'(rd_if.rd_req), 0);
        tick(10);
        rd_if.rd_done = 1'b1;
        tick();
        rd_if.rd_done = 1'b0;
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
    initial begin
        int seen;
        rd_if.rd_ack  = 1'b0;
        rd_if.rd_done = 1'b0;
        tick(3);
        chk("rst_rd_req", 32'(rd_if.rd_req), 0);
        chk("rst_rd_addr", 32'(rd_if.rd_addr), 0);
        chk("rst_rd_len", 32'(rd_if.rd_len), 0);
        chk("rst_fifo_clr", 32'(fifo_clr), 0);
        chk("rst_active", 32'(frame_active), 0);
        chk("rst_late", 32'(frame_late), 0);
        rst = 1'b0;
        tick(2);
        chk("idle_no_req", 32'(rd_if.rd_req), 0);
        // basic frame: three bursts, last one short
        push_frame(24'h0);
        vsync_fall();
        chk("clr_latency", 32'(fifo_clr), 1);
        tick();
        chk("clr_one_cycle", 32'(fifo_clr), 0);
        chk("active_set", 32'(frame_active), 1);
        tick();
        chk("req_latency", 32'(rd_if.rd_req), 1);
        serve(2);
        serve(20);
        serve(20);
        chk("active_before_done", 32'(frame_active), 1);
        tick();
        chk("active_fall", 32'(frame_active), 0);
        chk("no_late_basic", 32'(frame_late), 0);
        chk("queue_drained", 32'(exp_q.size()), 0);
        // flow control around the free-space boundary
        fifo_level = 11'd900;
        push_b(24'h0, 9'd256);
        vsync_fall();
        tick(12);
        chk("no_req_900", 32'(rd_if.rd_req), 0);
        fifo_level = 11'd769;
        tick(3);
        chk("no_req_769", 32'(rd_if.rd_req), 0);
        fifo_level = 11'd768;
        expect_req(2);
        // restart while a burst is outstanding
        rd_if.rd_ack = 1'b1;
        tick();
        rd_if.rd_ack = 1'b0;
        fifo_level = '0;
        tick(3);
        vsync_fall();
        chk("late_wait", 32'(frame_late), 1);
        tick();
        chk("late_one_cycle", 32'(frame_late), 0);
        tick(4);
        chk("no_clr_before_done", 32'(fifo_clr), 0);
        rd_if.rd_done = 1'b1;
        tick();
        rd_if.rd_done = 1'b0;
        chk("clr_after_done", 32'(fifo_clr), 1);
        push_b(24'h0, 9'd256);
        serve(4);
        // start and ack in the same cycle
        push_b(24'd256, 9'd256);
        expect_req(4);
        rd_if.rd_ack = 1'b1;
        frame_sync = 1'b0;
        tick();
        rd_if.rd_ack = 1'b0;
        frame_sync = 1'b1;
        chk("late_req_ack", 32'(frame_late), 1);
        chk("ack_wins_no_clr", 32'(fifo_clr), 0);
        chk("ack_wins_req_drop", 32'(rd_if.rd_req), 0);
        tick(5);
        chk("ack_wins_wait", 32'(fifo_clr), 0);
        rd_if.rd_done = 1'b1;
        tick();
        rd_if.rd_done = 1'b0;
        chk("ack_wins_flush", 32'(fifo_clr), 1);
        push_b(24'h0, 9'd256);
        serve(4);
        // reset while requesting
        push_b(24'd256, 9'd256);
        expect_req(4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_req", 32'(rd_if.rd_req), 0);
        chk("midrst_addr", 32'(rd_if.rd_addr), 0);
        chk("midrst_len", 32'(rd_if.rd_len), 0);
        chk("midrst_active", 32'(frame_active), 0);
        seen = 0;
        repeat (20) begin
            tick();
            seen |= int'(rd_if.rd_req);
        end
        chk("no_req_after_rst", 32'(seen), 0);
        // start in REQ without ack abandons the request
        push_b(24'h0, 9'd256);
        vsync_fall();
        expect_req(4);
        vsync_fall();
        chk("req_abandon_drop", 32'(rd_if.rd_req), 0);
        chk("req_abandon_late", 32'(frame_late), 1);
        chk("req_abandon_clr", 32'(fifo_clr), 1);
        push_frame(24'h0);
        serve(4);
        serve(20);
        serve(20);
        tick();
        chk("active_fall_2", 32'(frame_active), 0);
`ifdef LCD_SCHED_DOUBLE_BUF_EN
        wr_bank = 1'b1;
        push_frame(24'h080000);
        vsync_fall();
        expect_req(4);
        chk("bank_sel", 32'(rd_bank), 1);
        rd_if.rd_ack = 1'b1;
        tick();
        rd_if.rd_ack = 1'b0;
        wr_bank = 1'b0;
        tick(10);
        rd_if.rd_done = 1'b1;
        tick();
        rd_if.rd_done = 1'b0;
        serve(20);
        serve(20);
        chk("bank_held", 32'(rd_bank), 1);
        vsync_fall();
        tick();
        chk("bank_next_frame", 32'(rd_bank), 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
